// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave register interface.
// States, ACK levels and byte type.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_WAIT_STOP = 4'd9
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef logic [7:0] i2c_byte_t;

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Register-file bus between the I2C slave and the register file.
// master: the I2C slave side; slave: the register file side.
`timescale 1ns/1ps
interface i2c_slave_regif_if;
    import i2c_pkg::*;

    i2c_byte_t reg_addr;
    i2c_byte_t reg_wdata;
    logic      reg_wr;
    logic      reg_rd;
    i2c_byte_t reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr,
        output reg_rd,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr,
        input  reg_rd,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_line_cond.sv
// Pad conditioning for one I2C line: synchroniser, glitch filter
// and single-clock rise/fall pulses of the filtered level.
`timescale 1ns/1ps
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic line_f,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   line_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Metastability chain; idle bus level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
        end
    end

    // Flip the filtered level only after FILTER_LEN differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_f <= 1'b1;
            cnt    <= '0;
        end else if (sample == line_f) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            line_f <= sample;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_d <= 1'b1;
        end else begin
            line_d <= line_f;
        end
    end

    assign rise = line_f & ~line_d;
    assign fall = ~line_f & line_d;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C slave (7-bit address) bridging bus transfers onto an
// 8-bit register pointer bus; never stretches SCL.
`timescale 1ns/1ps
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_oe,
    output logic busy,
    i2c_slave_regif_if.master rif
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (scl_in),
        .line_f  (scl_f),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (sda_in),
        .line_f  (sda_f),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    i2c_state_t state;
    logic [2:0] bit_cnt;
    logic       got8;
    logic       ack_seen;
    logic       rw;
    logic       rd_s1;
    i2c_byte_t  shifter;
    i2c_byte_t  ptr;
    i2c_byte_t  addr_q;
    i2c_byte_t  wdata_q;
    logic       wr_q;
    logic       rd_q;
    i2c_byte_t  byte_in;

    assign byte_in = {shifter[6:0], sda_f};

    assign rif.reg_addr  = addr_q;
    assign rif.reg_wdata = wdata_q;
    assign rif.reg_wr    = wr_q;
    assign rif.reg_rd    = rd_q;

    // Protocol FSM: bit shifting, ACK driving, pointer and strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd7;
            got8     <= 1'b0;
            ack_seen <= 1'b0;
            rw       <= 1'b0;
            rd_s1    <= 1'b0;
            shifter  <= '0;
            ptr      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            rd_s1 <= rd_q;
            if (rd_s1) begin
                shifter <= rif.reg_rdata;
                if (state == S_RDATA) begin
                    sda_oe <= ~rif.reg_rdata[7];
                end
            end
            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= 3'd7;
                got8     <= 1'b0;
                ack_seen <= 1'b0;
                busy     <= 1'b1;
                sda_oe   <= 1'b0;
            end else if (stop_det) begin
                state    <= S_IDLE;
                got8     <= 1'b0;
                ack_seen <= 1'b0;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                unique case (state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise) begin
                            shifter <= byte_in;
                            if (bit_cnt == 3'd0) begin
                                got8 <= 1'b1;
                                if (state == S_WDATA) begin
                                    wr_q    <= 1'b1;
                                    wdata_q <= byte_in;
                                    addr_q  <= ptr;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end else if (scl_fall && got8) begin
                            got8 <= 1'b0;
                            if (state == S_ADDR) begin
                                if (shifter[7:1] == DEV_ADDR) begin
                                    sda_oe <= 1'b1;
                                    rw     <= shifter[0];
                                    state  <= S_ADDR_ACK;
                                end else begin
                                    state <= S_WAIT_STOP;
                                end
                            end else if (state == S_PTR) begin
                                ptr    <= shifter;
                                sda_oe <= 1'b1;
                                state  <= S_PTR_ACK;
                            end else begin
                                sda_oe <= 1'b1;
                                state  <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            if (!rw) begin
                                state <= S_PTR;
                            end else begin
                                rd_q   <= 1'b1;
                                addr_q <= ptr;
                                state  <= S_RDATA;
                            end
                        end
                    end
                    S_PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= S_WDATA;
                        end
                    end
                    S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= 3'd7;
                            state   <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= S_RDATA_ACK;
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                                sda_oe  <= ~shifter[6];
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_f == I2C_ACK) begin
                                ptr      <= ptr + 8'd1;
                                rd_q     <= 1'b1;
                                addr_q   <= ptr + 8'd1;
                                ack_seen <= 1'b1;
                            end else begin
                                state <= S_WAIT_STOP;
                            end
                        end else if (scl_fall && ack_seen) begin
                            ack_seen <= 1'b0;
                            sda_oe   <= ~shifter[7];
                            bit_cnt  <= 3'd7;
                            state    <= S_RDATA;
                        end
                    end
                    S_IDLE, S_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
